dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares one single-port, variable-latency data memory between the single-cycle core's load/store port and a DMA/program-loader requester.
- Sequences each access with a req/ack handshake to memory.
- Raises core_stall so the core holds PC and register writeback while its access is pending.
- Sits between riscvsingle's data port (MemWrite, ALUResult, WriteData, ReadData) and the data memory.

Parameters:
- ADDR_W, 32, address width for all ports.
- DATA_W, 32, data width for all ports.
- TIMEOUT, 15, cycles without mem_ack before a transfer is aborted (must be ≥1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- core_req  in  1  core has a load or store this instruction.
- core_we  in  1  1 = store (from MemWrite).
- core_addr  in  ADDR_W  access address (from ALUResult).
- core_wdata  in  DATA_W  store data (from WriteData).
- core_rdata  out  DATA_W  load data to core.
- core_ack  out  1  one-cycle pulse; access complete, core_rdata valid.
- core_stall  out  1  combinational: core_req & ~core_ack; gates PC and RegWrite.
- dma_req  in  1  DMA access request.
- dma_we  in  1  DMA write enable.
- dma_addr  in  ADDR_W  DMA address.
- dma_wdata  in  DATA_W  DMA write data.
- dma_rdata  out  DATA_W  DMA read data.
- dma_ack  out  1  one-cycle completion pulse.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack.
- mem_ack  in  1  memory completion, single cycle.
- err_timeout  out  1  sticky: a transfer was aborted.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, last_gnt=DMA (core wins the first tie), all outputs 0, timeout counter 0, err_timeout 0.
- States: IDLE, XFER_CORE, XFER_DMA.
- IDLE arbitration each cycle:
  - Only one requester active → that requester wins.
  - Both active → the requester that is not last_gnt wins (2-way round-robin).
  - Neither → stay in IDLE.
- On grant (cycle N): latch we/addr/wdata of the winner, update last_gnt, enter XFER_x. mem_req/mem_we/mem_addr/mem_wdata are registered outputs, so they appear from cycle N+1.
- XFER_x:
  - mem_req held at 1 with stable fields until mem_ack.
  - Cycle M with mem_ack=1: capture mem_rdata into x_rdata (writes capture 0), x_ack=1 in cycle M+1, mem_req=0 in cycle M+1, state=IDLE in cycle M+1.
  - Minimum latency req→ack is 2 cycles with a zero-wait memory (ack in N+1, x_ack in N+2).
  - x_rdata holds its value until the next ack to the same requester.
- Rearbitration: IDLE arbitrates in the same cycle as the x_ack pulse. A requester that just got ack and still has req high is a new request. Its fields must change by then, or a duplicate access results; the core advances PC on ack, so its fields do change.
- Timeout:
  - Counter clears on entry to XFER and increments each XFER cycle with mem_ack=0.
  - When count==TIMEOUT: mem_req drops, x_ack pulses with x_rdata=0, err_timeout sets, state=IDLE.
  - err_timeout clears only on reset.
  - mem_ack arriving in the same cycle as timeout: the ack wins, treated as a normal completion.
- Requester drops req mid-transfer: the transfer still completes on the memory side and the ack pulse is still issued. Requesters ignore unsolicited acks.
- mem_ack while in IDLE: ignored.
- Reset mid-transfer: mem_req drops asynchronously and no ack is issued. The memory must tolerate an abandoned request.
- core_stall stays high through arbitration loss and wait states; it is 0 when core_req=0.

Decomposition:
- Shared package dmem_arb_pkg:
  - State encoding localparams (IDLE=2'd0, XFER_CORE=2'd1, XFER_DMA=2'd2).
  - Requester ID localparams (GNT_CORE=1'b0, GNT_DMA=1'b1).
  - Timeout-counter width as $clog2(TIMEOUT+1).
- One natural sub-module: arb_rr2 (combinational 2-way round-robin picker; inputs req[1:0] and last_gnt, outputs gnt_valid and gnt_id).

Test Plan:
- Core load, zero-wait memory: core_req=1, core_addr=0x100, mem_rdata=0xCAFEF00D with ack in the first mem_req cycle → core_ack 2 cycles after req, core_rdata=0xCAFEF00D, core_stall high for exactly 2 cycles.
- Simultaneous first requests: core store 0x10 ← 0x11111111, DMA store 0x20 ← 0x22222222 → core served first (mem_addr=0x10), DMA next (mem_addr=0x20); the next tie goes to the core again.
- Wait states: memory acks after 3 cycles → mem_req and mem_addr stable for 4 cycles, single core_ack pulse, no second mem_req.
- Timeout: memory never acks, TIMEOUT=15 → mem_req drops after 15 waiting cycles, dma_ack=1 with dma_rdata=0, err_timeout=1 and stays 1 through later normal transfers.
- Reset during XFER_DMA with mem_req=1: rst=0 → mem_req=0 with no clock edge, no dma_ack; after release, a core request is granted first.
- Continuous DMA requests with the core issuing a load every instruction → grants alternate core/DMA, and the core never waits more than one DMA transfer plus its own.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM encoding,
// requester IDs and timeout-counter sizing.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StXferCore = 2'd1,
    StXferDma  = 2'd2
  } arb_state_e;

  localparam logic GNT_CORE = 1'b0;
  localparam logic GNT_DMA  = 1'b1;

  localparam int unsigned TIMEOUT_DEFAULT = 15;

  function automatic int unsigned cnt_width(input int unsigned timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// Combinational 2-way round-robin picker; on a tie the requester that was
// not granted last wins.
module arb_rr2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       gnt_valid,
  output logic       gnt_id
);

  always_comb begin
    gnt_valid = |req;
    gnt_id    = GNT_CORE;
    if (req == 2'b11) begin
      gnt_id = ~last_gnt;
    end else if (req[GNT_DMA]) begin
      gnt_id = GNT_DMA;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one variable-latency data memory between the core load/store port
// and a DMA requester, with req/ack sequencing, core stall and timeout abort.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_ack,
  output logic              core_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              err_timeout
);

  localparam int unsigned CntW = cnt_width(TIMEOUT);

  arb_state_e        state_q;
  logic              last_gnt_q;
  logic [CntW-1:0]   cnt_q;
  logic [CntW-1:0]   cnt_inc;
  logic              gnt_valid;
  logic              gnt_id;
  logic              xfer_end;
  logic [DATA_W-1:0] xfer_rdata;

  arb_rr2 u_arb_rr2 (
    .req       ({dma_req, core_req}),
    .last_gnt  (last_gnt_q),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  assign core_stall = core_req & ~core_ack;

  // An ack in the final waiting cycle beats the timeout.
  assign cnt_inc    = cnt_q + 1'b1;
  assign xfer_end   = mem_ack || (cnt_inc == CntW'(TIMEOUT));
  assign xfer_rdata = (mem_ack && !mem_we) ? mem_rdata : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      last_gnt_q  <= GNT_DMA;
      cnt_q       <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      core_rdata  <= '0;
      core_ack    <= 1'b0;
      dma_rdata   <= '0;
      dma_ack     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      core_ack <= 1'b0;
      dma_ack  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (gnt_valid) begin
            last_gnt_q <= gnt_id;
            cnt_q      <= '0;
            mem_req    <= 1'b1;
            if (gnt_id == GNT_CORE) begin
              state_q   <= StXferCore;
              mem_we    <= core_we;
              mem_addr  <= core_addr;
              mem_wdata <= core_wdata;
            end else begin
              state_q   <= StXferDma;
              mem_we    <= dma_we;
              mem_addr  <= dma_addr;
              mem_wdata <= dma_wdata;
            end
          end
        end
        StXferCore, StXferDma: begin
          if (xfer_end) begin
            mem_req <= 1'b0;
            state_q <= StIdle;
            if (!mem_ack) begin
              err_timeout <= 1'b1;
              cnt_q       <= cnt_inc;
            end
            if (state_q == StXferCore) begin
              core_rdata <= xfer_rdata;
              core_ack   <= 1'b1;
            end else begin
              dma_rdata <= xfer_rdata;
              dma_ack   <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: begin
          state_q <= StIdle;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed stimulus pushes expected memory
// transactions and acks; monitors pop and compare when the DUT presents them.
module tb_dmem_arbiter;

  localparam int unsigned TO = 15;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, core_we, core_ack, core_stall;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic        dma_req, dma_we, dma_ack;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic        mem_req, mem_we, mem_ack, err_timeout;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int tests = 0;
  int fails = 0;
  int mem_wait = 0;
  int waited = 0;

  mem_t        exp_mem[$];
  logic [31:0] exp_core[$];
  logic [31:0] exp_dma[$];

  dmem_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .core_req    (core_req),
    .core_we     (core_we),
    .core_addr   (core_addr),
    .core_wdata  (core_wdata),
    .core_rdata  (core_rdata),
    .core_ack    (core_ack),
    .core_stall  (core_stall),
    .dma_req     (dma_req),
    .dma_we      (dma_we),
    .dma_addr    (dma_addr),
    .dma_wdata   (dma_wdata),
    .dma_rdata   (dma_rdata),
    .dma_ack     (dma_ack),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a == 32'h100) return 32'hCAFE_F00D;
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got an event, expected none", name);
  endtask

  task automatic push_mem(input logic we, input logic [31:0] a, input logic [31:0] d);
    exp_mem.push_back({we, a, d});
  endtask

  // Memory model: acks after mem_wait cycles of mem_req.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (mem_req === 1'b1 && rst === 1'b1) begin
        if (waited == mem_wait) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_val(mem_addr);
          waited    = 0;
        end else begin
          waited++;
        end
      end else begin
        waited = 0;
      end
    end
  end

  // Memory-side monitor: order and fields at request start, stability while held.
  logic m_prev = 1'b0;
  logic m_unstable = 1'b0;
  mem_t m_cap;
  always @(negedge clk) begin
    if (mem_req === 1'b1 && !m_prev) begin
      if (exp_mem.size() == 0) begin
        flag("mem_extra_req");
      end else begin
        mem_t e;
        e = exp_mem.pop_front();
        check("mem_we", mem_we, e.we);
        check("mem_addr", mem_addr, e.addr);
        check("mem_wdata", mem_wdata, e.wdata);
      end
      m_cap      = {mem_we, mem_addr, mem_wdata};
      m_unstable = 1'b0;
    end else if (mem_req === 1'b1 && m_prev) begin
      if ({mem_we, mem_addr, mem_wdata} != m_cap) m_unstable = 1'b1;
    end else if (m_prev) begin
      check("mem_fields_stable", m_unstable, 1'b0);
    end
    m_prev = (mem_req === 1'b1);
  end

  // Ack monitor.
  always @(negedge clk) begin
    if (core_ack === 1'b1) begin
      if (exp_core.size() == 0) flag("core_unexpected_ack");
      else check("core_rdata", core_rdata, exp_core.pop_front());
    end
    if (dma_ack === 1'b1) begin
      if (exp_dma.size() == 0) flag("dma_unexpected_ack");
      else check("dma_rdata", dma_rdata, exp_dma.pop_front());
    end
  end

  // Waits for acks, dropping a request on its last ack and stepping the address otherwise.
  task automatic wait_acks(input int n_core, input int n_dma, input int budget,
                           output int max_stall, output int req_cycles, output int cycles);
    int cc = 0;
    int dc = 0;
    int run = 0;
    max_stall  = 0;
    req_cycles = 0;
    cycles     = 0;
    while ((cc < n_core || dc < n_dma) && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (mem_req) req_cycles++;
      if (core_stall) begin
        run++;
        if (run > max_stall) max_stall = run;
      end else begin
        run = 0;
      end
      if (core_ack) begin
        cc++;
        if (cc >= n_core) core_req = 1'b0;
        else core_addr = core_addr + 32'd4;
      end
      if (dma_ack) begin
        dc++;
        if (dc >= n_dma) dma_req = 1'b0;
        else dma_addr = dma_addr + 32'd4;
      end
    end
    check("core_acks_in_budget", cc, n_core);
    check("dma_acks_in_budget", dc, n_dma);
  endtask

  task automatic drive_core(input logic we, input logic [31:0] a, input logic [31:0] d);
    core_req = 1'b1; core_we = we; core_addr = a; core_wdata = d;
  endtask

  task automatic drive_dma(input logic we, input logic [31:0] a, input logic [31:0] d);
    dma_req = 1'b1; dma_we = we; dma_addr = a; dma_wdata = d;
  endtask

  int ms, rc, tc, hi;

  initial begin
    rst = 1'b0;
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_core_ack", core_ack, 1'b0);
    check("rst_dma_ack", dma_ack, 1'b0);
    check("rst_err", err_timeout, 1'b0);
    check("rst_core_rdata", core_rdata, 32'h0);
    check("rst_stall", core_stall, 1'b0);
    @(posedge clk); #1 rst = 1'b1;

    // First tie after reset: core first, then DMA.
    mem_wait = 0;
    push_mem(1'b1, 32'h10, 32'h1111_1111);
    push_mem(1'b1, 32'h20, 32'h2222_2222);
    exp_core.push_back(32'h0);
    exp_dma.push_back(32'h0);
    @(posedge clk); #1;
    drive_core(1'b1, 32'h10, 32'h1111_1111);
    drive_dma(1'b1, 32'h20, 32'h2222_2222);
    wait_acks(1, 1, 40, ms, rc, tc);

    // Next tie goes to the core again.
    push_mem(1'b0, 32'h30, 32'h0);
    push_mem(1'b0, 32'h40, 32'h0);
    exp_core.push_back(32'h0030_FFCF);
    exp_dma.push_back(32'h0040_FFBF);
    @(posedge clk); #1;
    drive_core(1'b0, 32'h30, 32'h0);
    drive_dma(1'b0, 32'h40, 32'h0);
    wait_acks(1, 1, 40, ms, rc, tc);

    // Core load, zero-wait memory.
    push_mem(1'b0, 32'h100, 32'h0);
    exp_core.push_back(32'hCAFE_F00D);
    @(posedge clk); #1;
    drive_core(1'b0, 32'h100, 32'h0);
    wait_acks(1, 0, 40, ms, rc, tc);
    check("zw_ack_latency", tc - 1, 2);
    check("zw_stall_cycles", ms, 2);

    // Three wait states.
    mem_wait = 3;
    push_mem(1'b0, 32'h200, 32'h0);
    exp_core.push_back(32'h0200_FDFF);
    @(posedge clk); #1;
    drive_core(1'b0, 32'h200, 32'h0);
    wait_acks(1, 0, 40, ms, rc, tc);
    check("ws_mem_req_cycles", rc, 4);
    check("ws_ack_latency", tc - 1, 5);
    hi = 0;
    repeat (4) begin
      @(negedge clk);
      if (mem_req) hi++;
    end
    check("ws_no_second_req", hi, 0);

    // Ack in the last waiting cycle beats the timeout.
    mem_wait = TO - 1;
    push_mem(1'b0, 32'h500, 32'h0);
    exp_dma.push_back(32'h0500_FAFF);
    @(posedge clk); #1;
    drive_dma(1'b0, 32'h500, 32'h0);
    wait_acks(0, 1, 60, ms, rc, tc);
    check("edge_mem_req_cycles", rc, TO);
    check("edge_no_err", err_timeout, 1'b0);

    // Memory never acks: abort after TO waiting cycles.
    mem_wait = 1000;
    push_mem(1'b0, 32'h300, 32'h0);
    exp_dma.push_back(32'h0);
    @(posedge clk); #1;
    drive_dma(1'b0, 32'h300, 32'h0);
    wait_acks(0, 1, 60, ms, rc, tc);
    check("to_mem_req_cycles", rc, TO);
    check("to_err_set", err_timeout, 1'b1);

    // Error stays sticky through a normal store.
    mem_wait = 0;
    push_mem(1'b1, 32'h400, 32'hA5A5_A5A5);
    exp_core.push_back(32'h0);
    @(posedge clk); #1;
    drive_core(1'b1, 32'h400, 32'hA5A5_A5A5);
    wait_acks(1, 0, 40, ms, rc, tc);
    check("to_err_sticky", err_timeout, 1'b1);

    // Reset mid DMA transfer.
    mem_wait = 1000;
    push_mem(1'b0, 32'h600, 32'h0);
    @(posedge clk); #1;
    drive_dma(1'b0, 32'h600, 32'h0);
    tc = 0;
    do begin
      @(negedge clk);
      tc++;
    end while (!mem_req && tc < 10);
    check("rst_mid_req_seen", mem_req, 1'b1);
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;
    dma_req = 1'b0;
    #1;
    check("rst_async_mem_req", mem_req, 1'b0);
    check("rst_async_err", err_timeout, 1'b0);
    check("rst_async_dma_ack", dma_ack, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    mem_wait = 0;
    push_mem(1'b0, 32'h700, 32'h0);
    push_mem(1'b0, 32'h800, 32'h0);
    exp_core.push_back(32'h0700_F8FF);
    exp_dma.push_back(32'h0800_F7FF);
    @(posedge clk); #1;
    drive_core(1'b0, 32'h700, 32'h0);
    drive_dma(1'b0, 32'h800, 32'h0);
    wait_acks(1, 1, 40, ms, rc, tc);

    // Continuous DMA with a core load every instruction: strict alternation.
    mem_wait = 1;
    for (int i = 0; i < 4; i++) begin
      push_mem(1'b0, 32'h1000 + 32'(4 * i), 32'h0);
      push_mem(1'b0, 32'h2000 + 32'(4 * i), 32'h0);
      exp_core.push_back(mem_val(32'h1000 + 32'(4 * i)));
      exp_dma.push_back(mem_val(32'h2000 + 32'(4 * i)));
    end
    @(posedge clk); #1;
    drive_core(1'b0, 32'h1000, 32'h0);
    drive_dma(1'b0, 32'h2000, 32'h0);
    wait_acks(4, 4, 200, ms, rc, tc);
    check("cont_core_max_stall", ms, 5);

    repeat (4) @(negedge clk);
    check("mem_queue_drained", exp_mem.size(), 0);
    check("core_queue_drained", exp_core.size(), 0);
    check("dma_queue_drained", exp_dma.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
